mult_sequencer: RTL and testbench

Control sequencer for the 8-bit shift-add signed multiplier datapath: XA register, B register and the 9-bit add/subtract unit. It turns the ClearA_LoadB and Run operator inputs into the per-cycle strobes Clr_XA, Ld_B, Ld_XA, Shift_En and Sub_Add. It runs N_BITS add/shift iterations, with a final subtract for two's-complement multipliers, and then holds the result until Run is released. It sits between the input synchronizers and the register unit in the multiplier top level.

---
 rtl/mult_sequencer.sv | 166 ++++++++++++++++
 tb/tb_mult_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mult_sequencer.sv
// mult_sequencer
// Control sequencer for the 8-bit shift-add signed multiplier datapath.
// Turns the ClearA_LoadB / Run operator requests into per-cycle strobes
// for the XA register, B register and the 9-bit add/subtract unit.
// Runs N_BITS add/shift iterations (the last add is a subtract for
// two's-complement multipliers), then holds the product until Run drops.
//
// Ports:
//   Clk           system clock, rising edge
//   Reset         asynchronous active-high reset, forces IDLE
//   Run           level request to start a multiply
//   ClearA_LoadB  clear XA and load B from the switches (IDLE only)
//   M             current B[0] from the register unit
//   Clr_XA        clear X and A
//   Ld_B          load B from switch data
//   Ld_XA         load adder result into X and A
//   Shift_En      arithmetic right shift of X:A:B
//   Sub_Add       1 = adder subtracts S, 0 = adder adds S
//   Busy          high in START, ADD and SHIFT
//   Done          high in HOLD
//   Count         current iteration index, 0 to N_BITS-1
module mult_sequencer #(
  parameter int N_BITS = 8,
  localparam int CW = (N_BITS > 1) ? $clog2(N_BITS) : 1
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Run,
  input  logic          ClearA_LoadB,
  input  logic          M,
  output logic          Clr_XA,
  output logic          Ld_B,
  output logic          Ld_XA,
  output logic          Shift_En,
  output logic          Sub_Add,
  output logic          Busy,
  output logic          Done,
  output logic [CW-1:0] Count
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] ADD   = 3'd2;
  localparam logic [2:0] SHIFT = 3'd3;
  localparam logic [2:0] HOLD  = 3'd4;

  localparam logic [CW-1:0] LAST = CW'(N_BITS - 1);

  logic [2:0]    state_r;
  logic [2:0]    state_next_s;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_next_s;
  logic          last_s;

  assign last_s = (count_r == LAST);
  assign Count  = count_r;

  // Next-state and iteration-counter logic.
  always_comb begin
    state_next_s = state_r;
    count_next_s = count_r;
    case (state_r)
      IDLE: begin
        // ClearA_LoadB wins over Run; loading B keeps us in IDLE.
        if (ClearA_LoadB) begin
          state_next_s = IDLE;
        end else if (Run) begin
          state_next_s = START;
        end else begin
          state_next_s = IDLE;
        end
      end
      START: begin
        count_next_s = '0;
        state_next_s = ADD;
      end
      ADD: begin
        state_next_s = SHIFT;
      end
      SHIFT: begin
        if (last_s) begin
          state_next_s = HOLD;
        end else begin
          count_next_s = count_r + CW'(1);
          state_next_s = ADD;
        end
      end
      HOLD: begin
        // No auto-restart: Run must drop before another multiply.
        if (Run) begin
          state_next_s = HOLD;
        end else begin
          state_next_s = IDLE;
        end
      end
      default: begin
        state_next_s = IDLE;
        count_next_s = '0;
      end
    endcase
  end

  // State and counter registers with asynchronous reset.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_r <= IDLE;
      count_r <= '0;
    end else begin
      state_r <= state_next_s;
      count_r <= count_next_s;
    end
  end

  // Output decode. Gated by Reset so an IDLE load request cannot leak
  // strobes while reset is held; Ld_XA is Mealy on M during ADD.
  always_comb begin
    Clr_XA   = 1'b0;
    Ld_B     = 1'b0;
    Ld_XA    = 1'b0;
    Shift_En = 1'b0;
    Sub_Add  = 1'b0;
    Busy     = 1'b0;
    Done     = 1'b0;
    if (!Reset) begin
      case (state_r)
        IDLE: begin
          if (ClearA_LoadB) begin
            Ld_B   = 1'b1;
            Clr_XA = 1'b1;
          end else begin
            Ld_B   = 1'b0;
            Clr_XA = 1'b0;
          end
        end
        START: begin
          Clr_XA = 1'b1;
          Busy   = 1'b1;
        end
        ADD: begin
          Ld_XA   = M;
          Sub_Add = last_s;
          Busy    = 1'b1;
        end
        SHIFT: begin
          Shift_En = 1'b1;
          Busy     = 1'b1;
        end
        HOLD: begin
          Done = 1'b1;
        end
        default: begin
          Done = 1'b0;
        end
      endcase
    end else begin
      Clr_XA   = 1'b0;
      Ld_B     = 1'b0;
      Ld_XA    = 1'b0;
      Shift_En = 1'b0;
      Sub_Add  = 1'b0;
      Busy     = 1'b0;
      Done     = 1'b0;
    end
  end

endmodule

// File: tb/tb_mult_sequencer.sv
// tb_mult_sequencer
// Drives mult_sequencer together with a small register unit (X, A, B and
// the 9-bit adder) and checks every cycle of each multiply against the
// expected strobe schedule and the signed product computed arithmetically.
module tb_mult_sequencer;

  logic       Clk;
  logic       Reset;
  logic       Run;
  logic       ClearA_LoadB;
  logic       M;
  logic       Clr_XA;
  logic       Ld_B;
  logic       Ld_XA;
  logic       Shift_En;
  logic       Sub_Add;
  logic       Busy;
  logic       Done;
  logic [2:0] Count;

  logic [7:0] sw;
  logic       x_r;
  logic [7:0] a_r;
  logic [7:0] b_r;
  logic [8:0] sum_s;
  logic [7:0] b_model;

  int n_checks;
  int n_pass;

  mult_sequencer #(.N_BITS(8)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Run          (Run),
    .ClearA_LoadB (ClearA_LoadB),
    .M            (M),
    .Clr_XA       (Clr_XA),
    .Ld_B         (Ld_B),
    .Ld_XA        (Ld_XA),
    .Shift_En     (Shift_En),
    .Sub_Add      (Sub_Add),
    .Busy         (Busy),
    .Done         (Done),
    .Count        (Count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Register unit the sequencer controls.
  assign M     = b_r[0];
  assign sum_s = Sub_Add ? ({a_r[7], a_r} - {sw[7], sw}) : ({a_r[7], a_r} + {sw[7], sw});

  always @(posedge Clk) begin
    if (Ld_B) b_r <= sw;
    if (Clr_XA) begin
      x_r <= 1'b0;
      a_r <= 8'h00;
    end else if (Ld_XA) begin
      {x_r, a_r} <= sum_s;
    end else if (Shift_En) begin
      {x_r, a_r, b_r} <= {x_r, x_r, a_r, b_r[7:1]};
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_strobes"}, 32'({Clr_XA, Ld_B, Ld_XA, Shift_En, Sub_Add}), 32'd0);
    chk({tag, "_busy"}, 32'(Busy), 32'd0);
    chk({tag, "_done"}, 32'(Done), 32'd0);
  endtask

  task automatic load_b(input logic [7:0] v);
    sw = v;
    ClearA_LoadB = 1'b1;
    #1;
    chk("loadb_ldb", 32'(Ld_B), 32'd1);
    chk("loadb_clr", 32'(Clr_XA), 32'd1);
    chk("loadb_busy", 32'(Busy), 32'd0);
    step();
    ClearA_LoadB = 1'b0;
    #1;
    chk("loadb_after", 32'({Ld_B, Clr_XA, Busy}), 32'd0);
    b_model = v;
  endtask

  // One multiply of s by b_model. Optional: release Run early, hold Run
  // for 10 cycles in HOLD, pulse ClearA_LoadB at cycle cla_at, or assert
  // Reset mid-cycle at cycle rst_at (abandons the multiply).
  task automatic do_mult(input logic [7:0] s, input bit early, input bit hold10,
                         input int cla_at, input int rst_at);
    logic [7:0]  b0;
    logic [15:0] exp_p;
    bit          is_add;
    bit          is_shift;
    int          it;
    b0    = b_model;
    exp_p = 16'($signed(s) * $signed(b0));
    sw    = s;
    Run   = 1'b1;
    #1;
    chk("cycle0_idle", 32'({Busy, Done}), 32'd0);
    for (int c = 1; c <= 18; c++) begin
      step();
      if (early && c == 2) Run = 1'b0;
      ClearA_LoadB = (c == cla_at);
      if (c == rst_at) begin
        #2;
        Reset = 1'b1;
        #1;
        chk_all_zero("reset_mid");
        chk("reset_mid_count", 32'(Count), 32'd0);
        Run = 1'b0;
        ClearA_LoadB = 1'b0;
        step();
        Reset = 1'b0;
        #1;
        chk_all_zero("after_reset");
        step();
        chk_all_zero("after_reset_idle");
        chk("after_reset_count", 32'(Count), 32'd0);
        return;
      end
      #1;
      is_add   = (c >= 2) && (c <= 17) && (c % 2 == 0);
      is_shift = (c >= 3) && (c <= 17) && (c % 2 == 1);
      it       = is_add ? (c - 2) / 2 : (c - 3) / 2;
      chk("clr_xa", 32'(Clr_XA), 32'(c == 1));
      chk("ld_b", 32'(Ld_B), 32'd0);
      chk("ld_xa", 32'(Ld_XA), 32'(is_add && b0[it]));
      chk("sub_add", 32'(Sub_Add), 32'(is_add && it == 7));
      chk("shift_en", 32'(Shift_En), 32'(is_shift));
      chk("busy", 32'(Busy), 32'(c < 18));
      chk("done", 32'(Done), 32'(c == 18));
      if (is_add || is_shift) chk("count", 32'(Count), 32'(it));
    end
    ClearA_LoadB = 1'b0;
    chk("product", 32'({a_r, b_r}), 32'(exp_p));
    b_model = exp_p[7:0];
    if (hold10 && !early) begin
      for (int k = 0; k < 10; k++) begin
        step();
        chk("hold_done", 32'(Done), 32'd1);
        chk("hold_strobes", 32'({Clr_XA, Ld_B, Ld_XA, Shift_En, Sub_Add, Busy}), 32'd0);
      end
    end
    Run = 1'b0;
    step();
    chk_all_zero("back_idle");
  endtask

  initial begin
    logic [7:0] rs;
    logic [7:0] rb;
    n_checks     = 0;
    n_pass       = 0;
    x_r          = 1'b0;
    a_r          = 8'h00;
    b_r          = 8'h00;
    b_model      = 8'h00;
    sw           = 8'h00;
    Run          = 1'b0;
    ClearA_LoadB = 1'b1;
    Reset        = 1'b1;
    #3;
    // Reset dominates a pending load request.
    chk_all_zero("reset");
    chk("reset_count", 32'(Count), 32'd0);
    ClearA_LoadB = 1'b0;
    step();
    step();
    Reset = 1'b0;
    step();
    step();
    chk_all_zero("idle_run0");
    chk("idle_count", 32'(Count), 32'd0);

    // 3 x 7 = 21 with Run held high through HOLD, then a chained multiply
    // that reuses the low product byte (0x15) as B.
    load_b(8'h07);
    do_mult(8'h03, 1'b0, 1'b1, 0, 0);
    chk("ab_3x7", 32'({a_r, b_r}), 32'h0015);
    do_mult(8'h02, 1'b0, 1'b0, 0, 0);
    chk("ab_chain", 32'({a_r, b_r}), 32'h002A);

    // 5 x -1 = -5 exercises every add and the final subtract.
    load_b(8'hFF);
    do_mult(8'h05, 1'b0, 1'b0, 0, 0);
    chk("ab_5xm1", 32'({a_r, b_r}), 32'hFFFB);

    // ClearA_LoadB during SHIFT_3 (cycle 9) must be ignored.
    load_b(8'h9C);
    do_mult(8'hE3, 1'b0, 1'b0, 9, 0);

    // Reset during ADD_5 (cycle 12).
    load_b(8'h5A);
    do_mult(8'h11, 1'b0, 1'b0, 0, 12);

    // Randomized operands, sometimes with Run released early.
    for (int r = 0; r < 8; r++) begin
      rs = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      load_b(rb);
      do_mult(rs, 1'($urandom_range(0, 1)), 1'b0, 0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
